rv32i_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the rv32i core.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and the instruction-field splitter.
- Consumes the splitter's opcode/funct fields plus the branch comparator result.
- Drives register-enable, mux-select and memory handshake signals for the datapath.

---
 rtl/rv32i_multicycle_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_multicycle_ctrl
//
// Control FSM for the multi-cycle rv32i core. It steps every instruction
// through FETCH / DECODE / EXEC / (MEM) / (WB) and drives the datapath
// register enables, mux selects and the instruction/data memory handshakes.
// The FSM is terminal in HALT, which is reached on ECALL/EBREAK or on an
// illegal instruction; only rst_n leaves it.
//
// Parameters
//   RESET_STATE_CYCLES  cycles spent in RESET after rst_n releases (1..15)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   opcode, funct3, funct7     instruction fields (stable from DECODE on)
//   branch_taken               comparator result, used in EXEC only
//   imem_req / imem_ready      instruction fetch handshake
//   dmem_req / dmem_we /
//   dmem_ready                 data access handshake (we: 1 = store)
//   ir_we, mdr_we, pc_we       datapath register enables
//   pc_sel                     0 = pc+4, 1 = pc+imm, 2 = (rs1+imm_I)&~1
//   alu_src_a / alu_src_b      0 = rs1 / rs2, 1 = pc / immediate
//   imm_sel                    0 I, 1 S, 2 B, 3 U, 4 J, 5 shamt
//   alu_op                     {mod, funct3}; 0000 = ADD, 1001 = PASS_B
//   rf_we, wb_sel              register write, 0 ALU / 1 MDR / 2 pc+4
//   halted, illegal            HALT status and its cause
//   state_o                    current state, for debug
// ---------------------------------------------------------------------------
module rv32i_multicycle_ctrl #(
   parameter int RESET_STATE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       branch_taken,
   output logic       imem_req,
   input  logic       imem_ready,
   output logic       dmem_req,
   output logic       dmem_we,
   input  logic       dmem_ready,
   output logic       ir_we,
   output logic       mdr_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       alu_src_a,
   output logic       alu_src_b,
   output logic [2:0] imm_sel,
   output logic [3:0] alu_op,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic       halted,
   output logic       illegal,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] IMM_I     = 3'd0;
   localparam logic [2:0] IMM_S     = 3'd1;
   localparam logic [2:0] IMM_B     = 3'd2;
   localparam logic [2:0] IMM_U     = 3'd3;
   localparam logic [2:0] IMM_J     = 3'd4;
   localparam logic [2:0] IMM_SHAMT = 3'd5;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_PASS_B = 4'b1001;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_JALR  = 2'd2;
   localparam logic [1:0] PC_IMM   = 2'd1;

   localparam logic [1:0] WB_MDR = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // Terminal count of the RESET dwell counter (counter starts at 0).
   localparam logic [3:0] RESET_LAST = 4'(RESET_STATE_CYCLES - 1);

   state_t     state, state_next;
   logic [3:0] reset_cnt, reset_cnt_next;
   logic       illegal_flag, illegal_flag_next;

   // -----------------------------------------------------------------------
   // Instruction class and legality
   // -----------------------------------------------------------------------
   logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
   logic is_op_imm, is_op, is_fence, is_system;
   logic is_shift_imm;
   logic instr_legal;

   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_op_imm = (opcode == OPC_OP_IMM);
   assign is_op     = (opcode == OPC_OP);
   assign is_fence  = (opcode == OPC_FENCE);
   assign is_system = (opcode == OPC_SYSTEM);

   // SLLI (001) and SRLI/SRAI (101) carry funct7 in the immediate field.
   assign is_shift_imm = is_op_imm && (funct3 == 3'b001 || funct3 == 3'b101);

   always_comb begin
      instr_legal = 1'b0;
      unique case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM:
            instr_legal = 1'b1;
         OPC_JALR:
            instr_legal = (funct3 == 3'b000);
         OPC_BRANCH:
            instr_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
         OPC_LOAD:
            instr_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
         OPC_STORE:
            instr_legal = (funct3 <= 3'b010);
         OPC_OP_IMM: begin
            if (funct3 == 3'b001)
               instr_legal = (funct7 == F7_ZERO);
            else if (funct3 == 3'b101)
               instr_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            else
               instr_legal = 1'b1;
         end
         OPC_OP: begin
            // Only SUB (000) and SRA (101) have an alternate-funct7 form.
            if (funct7 == F7_ZERO)
               instr_legal = 1'b1;
            else if (funct7 == F7_ALT)
               instr_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            else
               instr_legal = 1'b0;
         end
         default:
            instr_legal = 1'b0;
      endcase
   end

   // -----------------------------------------------------------------------
   // ALU-side controls of the EXEC step. MEM re-drives the same values so
   // the address stays valid for the whole data access.
   // -----------------------------------------------------------------------
   logic       ex_src_a;
   logic       ex_src_b;
   logic [2:0] ex_imm_sel;
   logic [3:0] ex_alu_op;

   always_comb begin
      ex_src_a   = 1'b0;
      ex_src_b   = 1'b0;
      ex_imm_sel = IMM_I;
      ex_alu_op  = ALU_ADD;
      if (is_op) begin
         ex_alu_op = {funct7[5], funct3};
      end else if (is_op_imm) begin
         ex_src_b   = 1'b1;
         ex_imm_sel = is_shift_imm ? IMM_SHAMT : IMM_I;
         // Only the right shift uses funct7[5] (SRAI); elsewhere it is imm bits.
         ex_alu_op  = {(funct3 == 3'b101) & funct7[5], funct3};
      end else if (is_lui) begin
         ex_imm_sel = IMM_U;
         ex_alu_op  = ALU_PASS_B;
      end else if (is_auipc) begin
         ex_src_a   = 1'b1;
         ex_src_b   = 1'b1;
         ex_imm_sel = IMM_U;
      end else if (is_load) begin
         ex_src_b   = 1'b1;
         ex_imm_sel = IMM_I;
      end else if (is_store) begin
         ex_src_b   = 1'b1;
         ex_imm_sel = IMM_S;
      end else if (is_branch) begin
         ex_imm_sel = IMM_B;
      end
   end

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_RESET;
         reset_cnt    <= 4'd0;
         illegal_flag <= 1'b0;
      end else begin
         state        <= state_next;
         reset_cnt    <= reset_cnt_next;
         illegal_flag <= illegal_flag_next;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next        = state;
      reset_cnt_next    = reset_cnt;
      illegal_flag_next = illegal_flag;
      unique case (state)
         S_RESET: begin
            if (reset_cnt == RESET_LAST)
               state_next = S_FETCH;
            else
               reset_cnt_next = reset_cnt + 4'd1;
         end
         S_FETCH: begin
            if (imem_ready)
               state_next = S_DECODE;
         end
         S_DECODE: begin
            if (!instr_legal) begin
               state_next        = S_HALT;
               illegal_flag_next = 1'b1;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_load || is_store)
               state_next = S_MEM;
            else if (is_branch || is_fence)
               state_next = S_FETCH;
            else if (is_system)
               state_next = S_HALT;
            else
               state_next = S_WB;
         end
         S_MEM: begin
            if (dmem_ready)
               state_next = is_store ? S_FETCH : S_WB;
         end
         S_WB: begin
            state_next = S_FETCH;
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_RESET;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Output logic (Mealy: ready / branch_taken feed straight through)
   // -----------------------------------------------------------------------
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      mdr_we    = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      imm_sel   = IMM_I;
      alu_op    = ALU_ADD;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      halted    = 1'b0;
      illegal   = 1'b0;
      state_o   = state;
      unique case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ready;
         end
         S_EXEC: begin
            alu_src_a = ex_src_a;
            alu_src_b = ex_src_b;
            imm_sel   = ex_imm_sel;
            alu_op    = ex_alu_op;
            if (is_branch) begin
               pc_we  = 1'b1;
               pc_sel = {1'b0, branch_taken};
            end else if (is_fence) begin
               pc_we  = 1'b1;
            end
         end
         S_MEM: begin
            alu_src_a = ex_src_a;
            alu_src_b = ex_src_b;
            imm_sel   = ex_imm_sel;
            alu_op    = ex_alu_op;
            dmem_req  = 1'b1;
            dmem_we   = is_store;
            if (dmem_ready) begin
               if (is_store)
                  pc_we  = 1'b1;
               else
                  mdr_we = 1'b1;
            end
         end
         S_WB: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
            if (is_load) begin
               wb_sel = WB_MDR;
            end else if (is_jal) begin
               wb_sel  = WB_PC4;
               pc_sel  = PC_IMM;
               imm_sel = IMM_J;
            end else if (is_jalr) begin
               wb_sel  = WB_PC4;
               pc_sel  = PC_JALR;
               imm_sel = IMM_I;
            end
         end
         S_HALT: begin
            halted  = 1'b1;
            illegal = illegal_flag;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_multicycle_ctrl
//
// Self-checking bench for rv32i_multicycle_ctrl. For every instruction the
// reference model expands the instruction class into its expected per-cycle
// output trace (fetch waits, decode, execute, memory waits, writeback or
// halt) and the bench replays it cycle by cycle, driving ready strobes,
// branch_taken and don't-care noise, then compares all outputs at once.
// ---------------------------------------------------------------------------
module tb_rv32i_multicycle_ctrl;

   localparam int RSC = 3;

   logic       clk;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       branch_taken;
   logic       imem_req;
   logic       imem_ready;
   logic       dmem_req;
   logic       dmem_we;
   logic       dmem_ready;
   logic       ir_we;
   logic       mdr_we;
   logic       pc_we;
   logic [1:0] pc_sel;
   logic       alu_src_a;
   logic       alu_src_b;
   logic [2:0] imm_sel;
   logic [3:0] alu_op;
   logic       rf_we;
   logic [1:0] wb_sel;
   logic       halted;
   logic       illegal;
   logic [2:0] state_o;

   rv32i_multicycle_ctrl #(.RESET_STATE_CYCLES(RSC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7       (funct7),
      .branch_taken (branch_taken),
      .imem_req     (imem_req),
      .imem_ready   (imem_ready),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ready   (dmem_ready),
      .ir_we        (ir_we),
      .mdr_we       (mdr_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .imm_sel      (imm_sel),
      .alu_op       (alu_op),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .halted       (halted),
      .illegal      (illegal),
      .state_o      (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All outputs bundled; field order matches the concatenation below.
   typedef struct packed {
      logic [2:0] st;
      logic       imem_req;
      logic       ir_we;
      logic       dmem_req;
      logic       dmem_we;
      logic       mdr_we;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       a;
      logic       b;
      logic [2:0] imm;
      logic [3:0] aluop;
      logic       rf_we;
      logic [1:0] wb;
      logic       halted;
      logic       ill;
   } outs_t;

   typedef struct {
      outs_t e;
      logic  ir;
      logic  dr;
      logic  bt;
      logic  junk;
   } cyc_t;

   outs_t act;
   assign act = {state_o, imem_req, ir_we, dmem_req, dmem_we, mdr_we, pc_we, pc_sel,
                 alu_src_a, alu_src_b, imm_sel, alu_op, rf_we, wb_sel, halted, illegal};

   int n_vec = 0;
   int n_bad = 0;
   int n_instr = 0;

   cyc_t q[$];
   logic [6:0] cur_opc;
   logic [2:0] cur_f3;
   logic [6:0] cur_f7;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic string phase_name(input logic [2:0] st);
      case (st)
         3'd0:    return "RESET";
         3'd1:    return "FETCH";
         3'd2:    return "DECODE";
         3'd3:    return "EXEC";
         3'd4:    return "MEM";
         3'd5:    return "WB";
         3'd6:    return "HALT";
         default: return "?";
      endcase
   endfunction

   // Legality straight from the ISA subset rules.
   function automatic bit legal(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
      case (o)
         7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111, 7'b1110011: return 1'b1;
         7'b1100111: return f3 == 3'b000;
         7'b1100011: return !(f3 inside {3'b010, 3'b011});
         7'b0000011: return !(f3 inside {3'b011, 3'b110, 3'b111});
         7'b0100011: return f3 <= 3'b010;
         7'b0010011: begin
            if (f3 == 3'b001) return f7 == 7'h00;
            if (f3 == 3'b101) return f7 inside {7'h00, 7'h20};
            return 1'b1;
         end
         7'b0110011: begin
            if (f7 == 7'h00) return 1'b1;
            if (f7 == 7'h20) return f3 inside {3'b000, 3'b101};
            return 1'b0;
         end
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input outs_t e, input logic ir, input logic dr, input logic bt, input logic junk);
      cyc_t c;
      c.e = e; c.ir = ir; c.dr = dr; c.bt = bt; c.junk = junk;
      q.push_back(c);
   endtask

   task automatic push_halt(input logic ill);
      outs_t o;
      for (int k = 0; k < 4; k++) begin
         o = '0; o.st = 3'd6; o.halted = 1'b1; o.ill = ill;
         push(o, rb(), rb(), rb(), 1'b0);
      end
   endtask

   // Expand one instruction into its expected cycle trace. Returns 1 when
   // the trace ends in HALT.
   task automatic build(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic bt, input int iw, input int dw, output bit halts);
      outs_t o, ex;
      bit is_ld, is_st, to_wb;
      cur_opc = opc; cur_f3 = f3; cur_f7 = f7;
      halts = 1'b0;
      // FETCH: request held through iw wait cycles, IR latched on the ready cycle
      for (int k = 0; k <= iw; k++) begin
         o = '0; o.st = 3'd1; o.imem_req = 1'b1; o.ir_we = (k == iw);
         push(o, (k == iw), rb(), rb(), 1'b1);
      end
      o = '0; o.st = 3'd2;
      push(o, rb(), rb(), rb(), 1'b0);
      if (!legal(opc, f3, f7)) begin
         push_halt(1'b1);
         halts = 1'b1;
         return;
      end
      is_ld = (opc == 7'b0000011);
      is_st = (opc == 7'b0100011);
      to_wb = 1'b1;
      ex = '0; ex.st = 3'd3;
      case (opc)
         7'b0110011: ex.aluop = {f7[5], f3};
         7'b0010011: begin
            ex.b = 1'b1;
            ex.imm = (f3 == 3'b001 || f3 == 3'b101) ? 3'd5 : 3'd0;
            ex.aluop = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
         end
         7'b0110111: begin ex.imm = 3'd3; ex.aluop = 4'b1001; end
         7'b0010111: begin ex.a = 1'b1; ex.b = 1'b1; ex.imm = 3'd3; end
         7'b0000011: begin ex.b = 1'b1; ex.imm = 3'd0; end
         7'b0100011: begin ex.b = 1'b1; ex.imm = 3'd1; end
         7'b1100011: begin ex.imm = 3'd2; ex.pc_we = 1'b1; ex.pc_sel = {1'b0, bt}; to_wb = 1'b0; end
         7'b0001111: begin ex.pc_we = 1'b1; to_wb = 1'b0; end
         7'b1110011: to_wb = 1'b0;
         default: ;
      endcase
      push(ex, rb(), rb(), bt, 1'b0);
      if (opc == 7'b1110011) begin
         push_halt(1'b0);
         halts = 1'b1;
         return;
      end
      if (is_ld || is_st) begin
         for (int k = 0; k <= dw; k++) begin
            o = ex; o.st = 3'd4; o.dmem_req = 1'b1; o.dmem_we = is_st;
            if (k == dw) begin
               if (is_st) o.pc_we = 1'b1; else o.mdr_we = 1'b1;
            end
            push(o, rb(), (k == dw), rb(), 1'b0);
         end
         if (is_st) to_wb = 1'b0;
      end
      if (to_wb) begin
         o = '0; o.st = 3'd5; o.rf_we = 1'b1; o.pc_we = 1'b1;
         if (is_ld) o.wb = 2'd1;
         else if (opc == 7'b1101111) begin o.wb = 2'd2; o.pc_sel = 2'd1; o.imm = 3'd4; end
         else if (opc == 7'b1100111) begin o.wb = 2'd2; o.pc_sel = 2'd2; o.imm = 3'd0; end
         push(o, rb(), rb(), rb(), 1'b0);
      end
   endtask

   task automatic step(input cyc_t c);
      @(negedge clk);
      imem_ready   = c.ir;
      dmem_ready   = c.dr;
      branch_taken = c.bt;
      if (c.junk) begin
         opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      end else begin
         opcode = cur_opc; funct3 = cur_f3; funct7 = cur_f7;
      end
      #1;
      check($sformatf("i%0d %s", n_instr, phase_name(c.e.st)), {7'd0, act}, {7'd0, c.e});
   endtask

   task automatic run_q(input int limit);
      int n = 0;
      while (q.size() > 0 && (limit < 0 || n < limit)) begin
         step(q.pop_front());
         n++;
      end
      q.delete();
   endtask

   // Called just after a sample point, so rst_n falls mid-cycle.
   task automatic apply_reset(input string why);
      outs_t z;
      #1 rst_n = 1'b0;
      #1;
      check({why, " async"}, {7'd0, act}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         imem_ready = rb(); dmem_ready = rb(); branch_taken = rb();
         #1;
         check({why, " held"}, {7'd0, act}, 32'd0);
      end
      rst_n = 1'b1;
      z = '0;
      for (int k = 1; k < RSC; k++) push(z, rb(), rb(), rb(), 1'b1);
      run_q(-1);
   endtask

   task automatic do_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic bt, input int iw, input int dw);
      bit h;
      n_instr++;
      build(opc, f3, f7, bt, iw, dw, h);
      run_q(-1);
      if (h) apply_reset("post-halt");
   endtask

   logic [6:0] legal_opc [11];

   initial begin
      legal_opc = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                    7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
      rst_n = 1'b1;
      opcode = '0; funct3 = '0; funct7 = '0;
      branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      apply_reset("reset");

      // Directed: ADD zero-wait, LW with 3 data waits, BEQ both ways, JALR
      do_instr(7'b0110011, 3'b000, 7'h00, 1'b0, 0, 0);
      do_instr(7'b0000011, 3'b010, 7'h00, 1'b0, 0, 3);
      do_instr(7'b1100011, 3'b000, 7'h00, 1'b1, 0, 0);
      do_instr(7'b1100011, 3'b000, 7'h00, 1'b0, 1, 0);
      do_instr(7'b1100111, 3'b000, 7'h00, 1'b0, 0, 0);

      // Reset dropped in the middle of a load's data access
      n_instr++;
      begin
         bit h;
         build(7'b0000011, 3'b010, 7'h00, 1'b0, 0, 3, h);
         run_q(5);   // FETCH, DECODE, EXEC, two MEM wait cycles
      end
      apply_reset("mid-MEM");

      // Directed halts: bad opcode, SLL with alternate funct7, ECALL
      do_instr(7'h7F, 3'b000, 7'h00, 1'b0, 0, 0);
      do_instr(7'b0110011, 3'b001, 7'h20, 1'b0, 0, 0);
      do_instr(7'b1110011, 3'b000, 7'h00, 1'b0, 0, 0);

      // Randomized instruction stream
      for (int i = 0; i < 300; i++) begin
         logic [6:0] opc, f7;
         int sel;
         opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_opc[$urandom_range(0, 10)];
         sel = $urandom_range(0, 5);
         f7 = (sel < 3) ? 7'h00 : (sel < 5) ? 7'h20 : 7'($urandom);
         do_instr(opc, 3'($urandom), f7, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
